// File: rtl/screen_framebuffer.sv
// ---------------------------------------------------------------------------
// screen_framebuffer: double-buffered RGB framebuffer feeding a HUB75 scanner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module screen_framebuffer #(
  parameter int COLS = 32,
  parameter int ROWS = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          rd,
  input  logic                          wr,
  input  logic [11:0]                   addr,
  input  logic [31:0]                   d_in,
  output logic [31:0]                   d_out,
  input  logic [$clog2(ROWS/2)-1:0]     scan_row,
  input  logic [$clog2(COLS)-1:0]       scan_col,
  input  logic                          scan_rd,
  input  logic                          frame_end,
  output logic [2:0]                    pix_top,
  output logic [2:0]                    pix_bot,
  output logic                          pix_valid
);

  localparam int HALF = COLS * ROWS / 2;
  localparam int HAW  = $clog2(HALF);
  localparam logic [11:0] C_CTRL_ADDR = 12'h800;
  localparam logic [11:0] C_FILL_ADDR = 12'h801;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            front_sel_q, front_sel_d;
  logic            swap_pending_q, swap_pending_d;
  logic [HAW-1:0]  fill_idx_q, fill_idx_d;
  logic [2:0]      fill_color_q, fill_color_d;
  logic [2:0]      fill_reg_q, fill_reg_d;
  logic [31:0]     d_out_q, d_out_d;
  logic [2:0]      pix_top_q, pix_top_d;
  logic [2:0]      pix_bot_q, pix_bot_d;
  logic            pix_valid_q, pix_valid_d;

  // [buffer][half-local index]; the two halves live in separate banks so a
  // fill can write both in one cycle
  logic [2:0]      mem_top [0:1][0:HALF-1];
  logic [2:0]      mem_bot [0:1][0:HALF-1];

  logic            fill_busy, back_sel, in_window;
  logic            bus_rd, bus_wr, ctrl_wr, fill_reg_wr, pix_wr, swap_now;
  logic            wr_top, wr_bot;
  logic [HAW-1:0]  wr_addr, scan_addr;
  logic [2:0]      wr_data, cpu_pix;
  logic            unused_d_in;

  assign unused_d_in = ^d_in[31:3];

  assign fill_busy   = (state_q == S_FILL);
  assign back_sel    = ~front_sel_q;
  assign in_window   = ~addr[11];
  assign bus_rd      = cs & rd;
  assign bus_wr      = cs & wr;
  assign ctrl_wr     = bus_wr & (addr == C_CTRL_ADDR);
  assign fill_reg_wr = bus_wr & (addr == C_FILL_ADDR);
  assign pix_wr      = bus_wr & in_window & ~fill_busy;
  assign swap_now    = frame_end & swap_pending_q & ~fill_busy;
  assign scan_addr   = {scan_row, scan_col};
  assign cpu_pix     = addr[HAW] ? mem_bot[back_sel][addr[HAW-1:0]]
                                 : mem_top[back_sel][addr[HAW-1:0]];

  always_comb begin
    state_d        = state_q;
    fill_idx_d     = fill_idx_q;
    fill_color_d   = fill_color_q;
    fill_reg_d     = fill_reg_q;
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q;

    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && d_in[1]) begin
          state_d      = S_FILL;
          fill_idx_d   = '0;
          fill_color_d = fill_reg_q;
        end
      end
      S_FILL: begin
        fill_idx_d = fill_idx_q + 1'b1;
        if (&fill_idx_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fill_reg_wr) fill_reg_d = d_in[2:0];

    // a swap request arriving with the committing frame_end waits a frame
    if (swap_now) begin
      front_sel_d    = ~front_sel_q;
      swap_pending_d = 1'b0;
    end else if (ctrl_wr && d_in[0]) begin
      swap_pending_d = 1'b1;
    end
  end

  always_comb begin
    wr_top  = 1'b0;
    wr_bot  = 1'b0;
    wr_addr = addr[HAW-1:0];
    wr_data = d_in[2:0];
    if (fill_busy) begin
      wr_top  = 1'b1;
      wr_bot  = 1'b1;
      wr_addr = fill_idx_q;
      wr_data = fill_color_q;
    end else if (pix_wr) begin
      wr_top = ~addr[HAW];
      wr_bot = addr[HAW];
    end
  end

  always_comb begin
    d_out_d     = d_out_q;
    pix_top_d   = pix_top_q;
    pix_bot_d   = pix_bot_q;
    pix_valid_d = scan_rd;
    if (bus_rd) begin
      if (in_window)                d_out_d = fill_busy ? 32'd0 : 32'(cpu_pix);
      else if (addr == C_CTRL_ADDR) d_out_d = 32'({fill_busy, swap_pending_q, front_sel_q});
      else if (addr == C_FILL_ADDR) d_out_d = 32'(fill_reg_q);
      else                          d_out_d = 32'd0;
    end
    if (scan_rd) begin
      pix_top_d = mem_top[front_sel_q][scan_addr];
      pix_bot_d = mem_bot[front_sel_q][scan_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_top) mem_top[back_sel][wr_addr] <= wr_data;
    if (wr_bot) mem_bot[back_sel][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      fill_idx_q     <= '0;
      fill_color_q   <= '0;
      fill_reg_q     <= '0;
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
      d_out_q        <= '0;
      pix_top_q      <= '0;
      pix_bot_q      <= '0;
      pix_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      fill_idx_q     <= fill_idx_d;
      fill_color_q   <= fill_color_d;
      fill_reg_q     <= fill_reg_d;
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
      d_out_q        <= d_out_d;
      pix_top_q      <= pix_top_d;
      pix_bot_q      <= pix_bot_d;
      pix_valid_q    <= pix_valid_d;
    end
  end

  assign d_out     = d_out_q;
  assign pix_top   = pix_top_q;
  assign pix_bot   = pix_bot_q;
  assign pix_valid = pix_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_screen_framebuffer.sv
// ---------------------------------------------------------------------------
// tb_screen_framebuffer: scoreboard bench with a behavioural framebuffer model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_screen_framebuffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] d_in = '0;
  logic [31:0] d_out;
  logic [3:0]  scan_row = '0;
  logic [4:0]  scan_col = '0;
  logic        scan_rd = 1'b0, frame_end = 1'b0;
  logic [2:0]  pix_top, pix_bot;
  logic        pix_valid;

  screen_framebuffer #(.COLS(32), .ROWS(32)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .d_in(d_in), .d_out(d_out), .scan_row(scan_row), .scan_col(scan_col),
    .scan_rd(scan_rd), .frame_end(frame_end), .pix_top(pix_top),
    .pix_bot(pix_bot), .pix_valid(pix_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: unexpected DUT output with empty scoreboard", name);
  endtask

  // Model: whole-screen pixel arrays per buffer, -1 marks never-written pixels
  int fb [2][1024];
  int m_front, m_pending, m_busy, m_idx, m_fcol, m_freg;

  typedef struct { int top; int bot; } pix_t;
  longint cpu_q [$];
  pix_t   pix_q [$];

  function automatic void model_reset();
    m_front = 0; m_pending = 0; m_busy = 0; m_idx = 0; m_fcol = 0; m_freg = 0;
  endfunction

  // Applies the rules for one clock cycle using the inputs currently driven
  function automatic void model_step();
    int   back  = 1 - m_front;
    int   pidx  = int'(addr[9:0]);
    int   sidx  = int'(scan_row) * 32 + int'(scan_col);
    bit   busy0 = (m_busy != 0);
    bit   commit = frame_end && (m_pending != 0) && !busy0;
    bit   ctrl  = cs && wr && (addr == 12'h800);
    pix_t p;
    if (cs && rd) begin
      if (!addr[11])           cpu_q.push_back(busy0 ? 0 : longint'(fb[back][pidx]));
      else if (addr == 12'h800) cpu_q.push_back(longint'(m_busy * 4 + m_pending * 2 + m_front));
      else if (addr == 12'h801) cpu_q.push_back(longint'(m_freg));
      else                      cpu_q.push_back(0);
    end
    if (scan_rd) begin
      p.top = fb[m_front][sidx];
      p.bot = fb[m_front][sidx + 512];
      pix_q.push_back(p);
    end
    if (busy0) begin
      fb[back][m_idx]       = m_fcol;
      fb[back][m_idx + 512] = m_fcol;
      if (m_idx == 511) m_busy = 0;
      m_idx = (m_idx + 1) % 512;
    end else if (cs && wr && !addr[11]) begin
      fb[back][pidx] = int'(d_in[2:0]);
    end
    if (ctrl && d_in[1] && !busy0) begin
      m_busy = 1; m_idx = 0; m_fcol = m_freg;
    end
    if (cs && wr && addr == 12'h801) m_freg = int'(d_in[2:0]);
    if (commit) begin
      m_front = 1 - m_front; m_pending = 0;
    end else if (ctrl && d_in[0]) begin
      m_pending = 1;
    end
  endfunction

  task automatic cyc(input bit c, input bit r, input bit w, input logic [11:0] a,
                     input logic [31:0] d, input bit srd, input logic [3:0] row,
                     input logic [4:0] col, input bit fe);
    @(posedge clk); #1;
    cs = c; rd = r; wr = w; addr = a; d_in = d;
    scan_rd = srd; scan_row = row; scan_col = col; frame_end = fe;
    model_step();
  endtask

  task automatic idle();                    cyc(0,0,0,12'h0,0,0,0,0,0); endtask
  task automatic bus_wr(input logic [11:0] a, input logic [31:0] d); cyc(1,0,1,a,d,0,0,0,0); endtask
  task automatic bus_rd(input logic [11:0] a); cyc(1,1,0,a,0,0,0,0,0); endtask
  task automatic scan(input logic [3:0] r, input logic [4:0] c); cyc(0,0,0,12'h0,0,1,r,c,0); endtask
  task automatic fend();                    cyc(0,0,0,12'h0,0,0,0,0,1); endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    cs = 0; rd = 0; wr = 0; scan_rd = 0; frame_end = 0;
    #1;
    check("rst_d_out", d_out, 0);
    check("rst_pix_top", pix_top, 0);
    check("rst_pix_bot", pix_bot, 0);
    check("rst_pix_valid", pix_valid, 0);
    model_reset();
    cpu_q.delete();
    pix_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: d_out is due the cycle after a bus read, pix_* when pix_valid
  logic   rd_seen, srd_seen;
  longint hold_exp = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_seen  <= 1'b0;
      srd_seen <= 1'b0;
    end else begin
      rd_seen  <= cs & rd;
      srd_seen <= scan_rd;
    end
  end

  always @(negedge clk) begin : monitor
    longint e;
    pix_t   p;
    if (rst) begin
      hold_exp = 0;
    end else begin
      if (rd_seen) begin
        if (cpu_q.size() == 0) fail_now("d_out_scoreboard");
        else begin
          e = cpu_q.pop_front();
          hold_exp = e;
          if (e >= 0) check("d_out", d_out, e);
        end
      end else if (hold_exp >= 0) begin
        check("d_out_hold", d_out, hold_exp);
      end
      check("pix_valid", pix_valid, srd_seen);
      if (pix_valid) begin
        if (pix_q.size() == 0) fail_now("pix_scoreboard");
        else begin
          p = pix_q.pop_front();
          if (p.top >= 0) check("pix_top", pix_top, p.top);
          if (p.bot >= 0) check("pix_bot", pix_bot, p.bot);
        end
      end
    end
  end

  initial begin
    foreach (fb[b, i]) fb[b][i] = -1;
    model_reset();
    #2;
    check("init_d_out", d_out, 0);
    check("init_pix_valid", pix_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // status after reset; scanner on unfilled buffer 0
    bus_rd(12'h800);
    scan(0, 0);
    scan(15, 31);

    // fill back buffer (1) with 3'b100, watch STATUS throughout
    bus_wr(12'h801, 32'h4);
    bus_rd(12'h801);
    bus_wr(12'h800, 32'h2);
    for (int i = 0; i < 515; i++) bus_rd(12'h800);
    bus_wr(12'h800, 32'h1);
    fend();
    bus_rd(12'h800);
    scan(0, 0);
    scan(15, 31);

    // fill buffer 0 too, then a single pixel at (5,20) and swap
    bus_wr(12'h800, 32'h2);
    for (int i = 0; i < 514; i++) idle();
    bus_wr(12'h000 + 12'(20 * 32 + 5), 32'h2);
    bus_rd(12'h000 + 12'(20 * 32 + 5));
    bus_wr(12'h800, 32'h1);
    fend();
    scan(4, 5);
    scan(4, 6);

    // swap request coinciding with frame_end waits for the next one
    cyc(1,0,1,12'h800,32'h1,0,0,0,1);
    bus_rd(12'h800);
    fend();
    bus_rd(12'h800);

    // swap deferred behind a fill; pixel write during fill is dropped
    bus_wr(12'h801, 32'h3);
    bus_wr(12'h800, 32'h3);
    bus_wr(12'h801, 32'h6);
    fend();
    bus_rd(12'h800);
    bus_wr(12'h000 + 12'(3 * 32 + 7), 32'h5);
    bus_rd(12'h000 + 12'(3 * 32 + 7));
    scan(3, 7);
    for (int i = 0; i < 600 && m_busy != 0; i++) idle();
    bus_rd(12'h800);
    bus_rd(12'h000 + 12'(3 * 32 + 7));
    fend();
    bus_rd(12'h800);
    scan(3, 7);
    scan(10, 0);

    // reset in the middle of a fill
    bus_wr(12'h800, 32'h2);
    for (int i = 0; i < 600 && !(m_busy != 0 && m_idx == 200); i++) idle();
    do_reset();
    bus_rd(12'h800);
    bus_rd(12'h801);
    bus_wr(12'h800, 32'h2);
    bus_rd(12'h800);
    for (int i = 0; i < 514; i++) idle();
    bus_rd(12'h800);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int          op = $urandom_range(0, 19);
      logic [11:0] a  = 12'($urandom_range(0, 2047));
      logic [31:0] d  = $urandom;
      bit          srd = ($urandom_range(0, 1) == 1);
      bit          fe  = ($urandom_range(0, 24) == 0);
      logic [3:0]  rr = 4'($urandom_range(0, 15));
      logic [4:0]  cc = 5'($urandom_range(0, 31));
      case (op)
        0, 1, 2, 3, 4: cyc(1,0,1,a,d,srd,rr,cc,fe);
        5, 6, 7, 8:    cyc(1,1,0,a,0,srd,rr,cc,fe);
        9:             cyc(1,1,0,12'h800,0,srd,rr,cc,fe);
        10:            cyc(1,($urandom_range(0,1) == 1),~rd,12'h801,d,srd,rr,cc,fe);
        11:            cyc(1,0,1,12'h800,{30'd0, ($urandom_range(0,60) == 0), d[0]},srd,rr,cc,fe);
        12, 13:        cyc(1,d[4],~d[4],12'h802 + 12'($urandom_range(0, 2045)),d,srd,rr,cc,fe);
        default:       cyc(0,0,0,a,d,srd,rr,cc,fe);
      endcase
    end

    idle();
    idle();
    idle();
    check("cpu_q_drained", cpu_q.size(), 0);
    check("pix_q_drained", pix_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/screen_framebuffer.md
Name: screen_framebuffer

Overview:
- Double-buffered RGB framebuffer sitting directly upstream of the 32x32 HUB75 scan driver.
- CPU side: SoC peripheral bus (cs/rd/wr/addr/d_in/d_out) writes pixels into the back buffer and requests swap/fill operations.
- Scanner side: the scan driver reads the front buffer as top/bottom pixel pairs (rows r and r+16).
- Buffer swaps are synchronised to the scanner's frame_end pulse, so no frame ever tears.

Parameters:
- COLS, 32, pixels per row (power of two).
- ROWS, 32, pixel rows; the scanner drives ROWS/2 row addresses.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cs  in  1  peripheral select
- rd  in  1  bus read strobe (qualified by cs)
- wr  in  1  bus write strobe (qualified by cs)
- addr  in  12  word offset
- d_in  in  32  bus write data
- d_out  out  32  bus read data, registered
- scan_row  in  4  row pair index 0..15 from the scanner
- scan_col  in  5  column 0..31 from the scanner
- scan_rd  in  1  scanner read request
- frame_end  in  1  one-cycle pulse from the scanner after the last row is latched
- pix_top  out  3  {R,G,B} at (scan_row, scan_col)
- pix_bot  out  3  {R,G,B} at (scan_row+16, scan_col)
- pix_valid  out  1  pulse: pix_top/pix_bot are valid

Behaviour:
- Storage:
  - Four 512x3 banks: {buffer 0/1} x {top half/bottom half}. The bank index within a half is y[3:0]*32+x.
  - Memory contents are not reset.
- Address map:
  - addr[11]=0: pixel window; addr[9:0] = y*32+x; y[4] selects the half.
  - addr 0x800: CTRL/STATUS.
  - addr 0x801: FILL colour.
  - Any other address: writes ignored, reads return 0.
- Pixel write (cs&wr, window): writes d_in[2:0] ({R,G,B}) into the back buffer (bank ~front_sel) in the same cycle. The write is dropped while fill_busy=1.
- Pixel read (cs&rd, window): d_out = {29'b0, pixel} from the back buffer one cycle later. Returns 0 while fill_busy=1.
- CTRL write:
  - d_in[0]=1 sets swap_pending; no effect if already pending.
  - d_in[1]=1 starts a fill; ignored if fill_busy=1.
  - Both bits may be set in the same write.
- STATUS read: d_out = {29'b0, fill_busy, swap_pending, front_sel}, one-cycle latency.
- FILL register: 3 bits, read/write, reset value 0.
- d_out holds its value when there is no read. It is never updated by writes.
- Fill FSM states:
  - IDLE -> FILL on a fill request: fill_busy=1, fill_idx=0.
  - FILL: each cycle writes the FILL colour to fill_idx in both back-buffer halves, then increments fill_idx. At fill_idx=511 the write occurs and the FSM returns to IDLE.
  - Fill time is exactly 512 cycles; fill_busy is cleared on the cycle after the final write.
  - The fill colour is captured at start; FILL register writes during a fill do not affect it.
- Swap: in a cycle where frame_end=1, swap_pending=1 and fill_busy=0:
  - front_sel toggles and swap_pending clears on the next edge.
  - If fill_busy=1, the swap defers to the first frame_end after the fill completes.
  - A CTRL swap write and frame_end in the same cycle: pending is set, and the swap waits for the next frame_end.
- Scanner read:
  - scan_rd in cycle N -> pix_top/pix_bot from the front buffer and pix_valid=1 in cycle N+1.
  - pix_valid=0 otherwise; pix_top/pix_bot hold their last values.
  - Buffer selection uses the front_sel value present in cycle N, even if a swap commits at that edge.
  - The scanner port is never stalled and never conflicts with the CPU port (different buffers).
- Reset, asynchronous: front_sel=0, swap_pending=0, fill_busy=0, FSM=IDLE, FILL=0, d_out=0, pix_top=0, pix_bot=0, pix_valid=0.
  - Reset during a fill aborts it; the partially filled buffer stays as written.

Test Plan:
- Reset, then STATUS read -> d_out=0x0. Scanner reads return pix_valid one cycle after scan_rd, with data from buffer 0 (undefined until filled).
- Fill 0b100 (FILL=4, CTRL=0x2):
  - STATUS reads 0x4 for 512 cycles, then 0x0.
  - Then CTRL=0x1 and pulse frame_end -> STATUS=0x1; scan reads at (0,0) and (15,31) return pix_top=pix_bot=3'b100.
- Write pixel (x=5, y=20) = 3'b010 to the back buffer, swap at frame_end -> scan_row=4, scan_col=5 returns pix_bot=3'b010 and pix_top=the fill colour.
- CTRL=0x1 in the same cycle as frame_end -> front_sel unchanged. The next frame_end toggles it.
- Start a fill, set swap, pulse frame_end mid-fill -> no swap, and a pixel write during the fill is dropped. The first frame_end after the fill swaps.
- Assert rst at fill_idx=200 -> all outputs and STATUS return to 0 immediately; a new fill request is accepted afterwards.
